// File: rtl/reg_mailbox_pkg.sv
// Shared types for the register mailbox: status word layout and level-width helper.
// Status struct is sized for the default depth; the top derives its own width from DEPTH.
package reg_mailbox_pkg;

   function automatic int lw_of(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int MBOX_DEPTH_DEF = 4;
   localparam int MBOX_LW_DEF    = lw_of(MBOX_DEPTH_DEF);

   typedef struct packed {
      logic [MBOX_LW_DEF-1:0] rx_lvl;
      logic [MBOX_LW_DEF-1:0] tx_lvl;
      logic                   rx_udf;
      logic                   tx_ovf;
      logic                   rx_empty;
      logic                   tx_full;
   } mbox_status_t;

endpackage

// File: rtl/reg_mailbox_fifo_sync.sv
// Single-clock FIFO with wrap-bit pointers; head is read combinationally (zero latency),
// push is ignored when full and pop is ignored when empty, both judged on pre-edge state.
module reg_mailbox_fifo_sync
   import reg_mailbox_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   localparam int LW   = lw_of(DEPTH),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level,
   output logic [DW-1:0] head
);

   logic [LW-1:0] wptr;
   logic [LW-1:0] rptr;
   logic [DW-1:0] mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   // Full when the pointers index the same slot but sit on different laps.
   assign empty   = (wptr == rptr);
   assign full    = (wptr[LW-1] != rptr[LW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign level   = wptr - rptr;
   assign head    = mem[rptr[AW-1:0]];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/reg_mailbox_fifo.sv
// hwext mailbox: SW writes feed a TX FIFO drained by HW, HW fills an RX FIFO popped by SW reads.
// Sticky overflow/underflow flags; optional level irq_o when REG_MAILBOX_IRQ_EN is defined.
module reg_mailbox_fifo
   import reg_mailbox_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   localparam int LW   = lw_of(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            reg_we_i,
   input  logic [DW-1:0]   reg_wdata_i,
   input  logic            reg_re_i,
   output logic [DW-1:0]   reg_rdata_o,
   input  logic            err_clr_i,
   output logic [2*LW+3:0] status_o,
   output logic            tx_valid_o,
   output logic [DW-1:0]   tx_data_o,
   input  logic            tx_ready_i,
   input  logic            rx_valid_i,
   input  logic [DW-1:0]   rx_data_i,
   output logic            rx_ready_o
`ifdef REG_MAILBOX_IRQ_EN
   ,
   output logic            irq_o
`endif
);

   logic          tx_full, tx_empty;
   logic          rx_full, rx_empty;
   logic [LW-1:0] tx_lvl, rx_lvl;
   logic [DW-1:0] rx_head;
   logic          tx_ovf, rx_udf;

   reg_mailbox_fifo_sync #(.DW(DW), .DEPTH(DEPTH)) u_tx (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (reg_we_i),
      .push_data (reg_wdata_i),
      .pop       (tx_ready_i),
      .full      (tx_full),
      .empty     (tx_empty),
      .level     (tx_lvl),
      .head      (tx_data_o)
   );

   reg_mailbox_fifo_sync #(.DW(DW), .DEPTH(DEPTH)) u_rx (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (rx_valid_i),
      .push_data (rx_data_i),
      .pop       (reg_re_i),
      .full      (rx_full),
      .empty     (rx_empty),
      .level     (rx_lvl),
      .head      (rx_head)
   );

   assign tx_valid_o  = ~tx_empty;
   assign rx_ready_o  = ~rx_full;
   assign reg_rdata_o = rx_empty ? '0 : rx_head;
   assign status_o    = {rx_lvl, tx_lvl, rx_udf, tx_ovf, rx_empty, tx_full};

   // A new error in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_ovf <= 1'b0;
         rx_udf <= 1'b0;
      end else begin
         if (reg_we_i & tx_full)  tx_ovf <= 1'b1;
         else if (err_clr_i)      tx_ovf <= 1'b0;
         if (reg_re_i & rx_empty) rx_udf <= 1'b1;
         else if (err_clr_i)      rx_udf <= 1'b0;
      end
   end

`ifdef REG_MAILBOX_IRQ_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) irq_o <= 1'b0;
      else       irq_o <= ~rx_empty | tx_ovf | rx_udf;
   end
`endif

endmodule

// File: tb/tb_reg_mailbox_fifo.sv
// Bench for reg_mailbox_fifo: queue-based model checked every cycle plus directed literal checks.
module tb_reg_mailbox_fifo;
   import reg_mailbox_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LW    = lw_of(DEPTH);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            reg_we = 1'b0;
   logic [DW-1:0]   reg_wdata = '0;
   logic            reg_re = 1'b0;
   logic [DW-1:0]   reg_rdata;
   logic            err_clr = 1'b0;
   logic [2*LW+3:0] status;
   logic            tx_valid;
   logic [DW-1:0]   tx_data;
   logic            tx_ready = 1'b0;
   logic            rx_valid = 1'b0;
   logic [DW-1:0]   rx_data = '0;
   logic            rx_ready;
`ifdef REG_MAILBOX_IRQ_EN
   logic            irq;
`endif

   mbox_status_t st;
   assign st = status;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] txq[$];
   logic [DW-1:0] rxq[$];
   logic          ovf_m = 1'b0;
   logic          udf_m = 1'b0;
   logic          irq_m = 1'b0;
   int            m_tsz, m_rsz;
   logic [DW-1:0] wvals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

   reg_mailbox_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .reg_we_i    (reg_we),
      .reg_wdata_i (reg_wdata),
      .reg_re_i    (reg_re),
      .reg_rdata_o (reg_rdata),
      .err_clr_i   (err_clr),
      .status_o    (status),
      .tx_valid_o  (tx_valid),
      .tx_data_o   (tx_data),
      .tx_ready_i  (tx_ready),
      .rx_valid_i  (rx_valid),
      .rx_data_i   (rx_data),
      .rx_ready_o  (rx_ready)
`ifdef REG_MAILBOX_IRQ_EN
      ,
      .irq_o       (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mailbox model: two bounded queues and sticky flags, all decisions on pre-edge sizes.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         txq.delete();
         rxq.delete();
         ovf_m <= 1'b0;
         udf_m <= 1'b0;
         irq_m <= 1'b0;
      end else begin
         m_tsz = txq.size();
         m_rsz = rxq.size();
         irq_m <= (m_rsz != 0) || ovf_m || udf_m;
         if (m_tsz != 0 && tx_ready) void'(txq.pop_front());
         if (reg_we && m_tsz < DEPTH) txq.push_back(reg_wdata);
         if (reg_we && m_tsz == DEPTH) ovf_m <= 1'b1;
         else if (err_clr)             ovf_m <= 1'b0;
         if (reg_re && m_rsz != 0) void'(rxq.pop_front());
         if (rx_valid && m_rsz < DEPTH) rxq.push_back(rx_data);
         if (reg_re && m_rsz == 0) udf_m <= 1'b1;
         else if (err_clr)         udf_m <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("tx_valid", tx_valid, txq.size() != 0);
         if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
         chk("rx_ready", rx_ready, rxq.size() < DEPTH);
         chk("reg_rdata", reg_rdata, (rxq.size() != 0) ? rxq[0] : '0);
         chk("status", status, {LW'(rxq.size()), LW'(txq.size()), udf_m, ovf_m,
                                rxq.size() == 0, txq.size() == DEPTH});
`ifdef REG_MAILBOX_IRQ_EN
         chk("irq", irq, irq_m);
`endif
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_status", status, 10'h002);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_rdata", reg_rdata, 0);

      // TX fill to full, then overflow
      reg_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         reg_wdata = wvals[i];
         tick();
      end
      reg_wdata = 32'h55;
      tick();
      reg_we = 1'b0;
      tick();
      chk("tx_full", st.tx_full, 1);
      chk("tx_lvl4", st.tx_lvl, 4);
      chk("tx_ovf", st.tx_ovf, 1);
      chk("tx_head", tx_data, 32'h11);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("tx_drain", tx_data, wvals[i]);
         tick();
      end
      tx_ready = 1'b0;
      chk("tx_drained", tx_valid, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("ovf_clr", st.tx_ovf, 0);

      // RX push two, read three
      rx_valid = 1'b1;
      rx_data  = 32'hA0;
      tick();
      rx_data  = 32'hA1;
      tick();
      rx_valid = 1'b0;
      reg_re   = 1'b1;
      chk("rx_rd0", reg_rdata, 32'hA0);
      tick();
      chk("rx_rd1", reg_rdata, 32'hA1);
      tick();
      chk("rx_rd2", reg_rdata, 0);
      tick();
      reg_re = 1'b0;
      chk("rx_udf", st.rx_udf, 1);
      chk("rx_empty", st.rx_empty, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("udf_clr", st.rx_udf, 0);

      // Full TX: write + HW pop + clear in the same cycle
      reg_we = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         reg_wdata = DW'(i);
         tick();
      end
      reg_wdata = 32'h99;
      tx_ready  = 1'b1;
      err_clr   = 1'b1;
      tick();
      reg_we  = 1'b0;
      tx_ready = 1'b0;
      err_clr = 1'b0;
      chk("full_pop_lvl", st.tx_lvl, 3);
      chk("full_pop_ovf", st.tx_ovf, 1);
      chk("full_pop_head", tx_data, 2);
      tx_ready = 1'b1;
      repeat (3) tick();
      tx_ready = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("tx_empty_again", tx_valid, 0);

      // TX streaming across pointer wrap
      reg_we    = 1'b1;
      reg_wdata = 32'h100;
      chk("tx_lat_pre", tx_valid, 0);
      tick();
      chk("tx_lat_post", tx_valid, 1);
      tx_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         reg_wdata = 32'h100 + DW'(i);
         tick();
         chk("tx_wrap_lvl", st.tx_lvl, 1);
         chk("tx_wrap_head", tx_data, 32'h100 + DW'(i));
      end
      reg_we = 1'b0;
      tick();
      tx_ready = 1'b0;

      // RX push+pop on empty, then streaming across wrap
      rx_valid = 1'b1;
      rx_data  = 32'h200;
      reg_re   = 1'b1;
      chk("rx_pp_empty_rd", reg_rdata, 0);
      tick();
      chk("rx_pp_udf", st.rx_udf, 1);
      chk("rx_pp_lvl", st.rx_lvl, 1);
      for (int i = 1; i <= 10; i++) begin
         rx_data = 32'h200 + DW'(i);
         chk("rx_wrap_rd", reg_rdata, 32'h200 + DW'(i - 1));
         tick();
         chk("rx_wrap_lvl", st.rx_lvl, 1);
      end
      rx_valid = 1'b0;
      chk("rx_wrap_last", reg_rdata, 32'h20A);
      tick();
      reg_re  = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("rx_wrap_empty", st.rx_empty, 1);

      // Asynchronous reset mid-cycle with data in both FIFOs
      reg_we   = 1'b1;
      rx_valid = 1'b1;
      reg_wdata = 32'h77;
      rx_data   = 32'h88;
      tick();
      tick();
      reg_we   = 1'b0;
      rx_valid = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_status", status, 10'h002);
      chk("arst_tx_valid", tx_valid, 0);
      chk("arst_rdata", reg_rdata, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();

`ifdef REG_MAILBOX_IRQ_EN
      rx_valid = 1'b1;
      rx_data  = 32'h5;
      tick();
      rx_valid = 1'b0;
      tick();
      chk("irq_set", irq, 1);
      reg_re = 1'b1;
      chk("irq_rd", reg_rdata, 32'h5);
      tick();
      reg_re = 1'b0;
      tick();
      chk("irq_clr", irq, 0);
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
